drum_line: RTL and testbench
============================

DRUM_LINE -- requirements
Module: drum_line

Interface
REQ-001 SHALL have parameter WORDS, default 108, words per line (108 long line, 4 short line); legal 2..108.
REQ-002 SHALL have parameter WORD_BITS, default 29, bits per word.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: CLOCK  input  1  system clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 BIT_EN  input  1  one-cycle strobe per drum bit time; never asserted on two consecutive cycles.
REQ-006 M_in  input  1  serial write-amplifier bit from memory-line logic (e.g. M0_in..M22_in).
REQ-007 M_out  output  1  serial read-head bit for the current position (e.g. M0..M23).
REQ-008 WORD_IDX  output  7  current word position w, 0..WORDS-1.
REQ-009 BIT_IDX  output  5  current bit position b, 0..WORD_BITS-1; b=0 is the LSB, first in time.
REQ-010 host_req  input  1  host word-access request; held high until host_ack.
REQ-011 host_we  input  1  1 write, 0 read; stable while host_req high.
REQ-012 host_addr  input  7  host word address; stable while host_req high.
REQ-013 host_wdata  input  WORD_BITS  host write data.
REQ-014 host_ack  output  1  one-cycle completion pulse.
REQ-015 host_rdata  output  WORD_BITS  read data, valid in the host_ack cycle, held until next ack.

Function
REQ-016 Storage SHALL be a single-port WORDS x WORD_BITS word RAM; one access (read or write) per CLOCK.
REQ-017 Position (w,b) SHALL advance only on BIT_EN: b increments; at b=WORD_BITS-1 b wraps to 0 and w increments; at w=WORDS-1,b=WORD_BITS-1 both wrap to 0.
REQ-018 M_out SHALL equal bit b of the current word's output shift register for the whole bit time, changing only in the cycle after a BIT_EN.
REQ-019 On each BIT_EN, M_in SHALL be captured as bit b of the input assembly register for word w.
REQ-020 On the BIT_EN at b=WORD_BITS-1, the assembled word (bits 0..27 captured plus M_in) SHALL be written to RAM[w] in that same cycle.
REQ-021 During bit time b=WORD_BITS-2, on the first cycle without BIT_EN, RAM[(w+1) mod WORDS] SHALL be read into the prefetch register; it SHALL load the output shift register on the wrap to b=0.
REQ-022 Net delay from M_in at (w,b) to the same bit on M_out SHALL be exactly WORDS*WORD_BITS bit times.
REQ-023 Arbiter: drum writeback and prefetch SHALL have priority; host access SHALL take a cycle with no drum access.
REQ-024 Host access to host_addr SHALL be blocked while host_addr == w, or while b >= WORD_BITS-2 and host_addr == (w+1) mod WORDS; it proceeds at the first unblocked free cycle.
REQ-025 host_ack SHALL pulse the cycle after the granted RAM access; one access per request; new request accepted only after host_req sampled low or the cycle following ack.
REQ-026 host_addr >= WORDS SHALL be acked without RAM access; reads return 0, writes discarded.
REQ-027 Host FSM states: IDLE -> WAIT (blocked or drum busy) -> ACCESS -> ACK -> IDLE; IDLE -> ACCESS directly when unblocked.

Reset
REQ-028 While rst_n low: w=0, b=0, M_out=0, host_ack=0, host_rdata=0, shift/assembly/prefetch registers 0, host FSM IDLE.
REQ-029 RAM contents SHALL be unaffected by reset.
REQ-030 After reset release, first revolution word 0 SHALL output 0 (registers cleared), then RAM[1] prefetch proceeds normally; a host request in flight at reset SHALL be dropped with no ack.

Verification
REQ-031 WORDS=4: host write addr 2 = 0x15555555, M_in=M_out loop -> M_out during w=2 reads 1,0,1,0,...,1 (b=0..28), repeats every 116 bit times.
REQ-032 WORDS=4, RAM zero, M_in=1 only at (w=1,b=5) -> M_out=1 exactly at (w=1,b=5) next revolution, 116 BIT_EN later, 0 elsewhere.
REQ-033 Host read of addr==w issued at b=3 -> no ack until w advances; ack data equals word as written back at end of that word time.
REQ-034 Host write addr 3 at (w=2,b=27) -> held until w=0; next revolution word 3 shows new data.
REQ-035 Position wrap: WORDS=108, count 3132 BIT_EN -> WORD_IDX/BIT_IDX return to 0/0; host addr 120 read -> ack, rdata 0.
REQ-036 rst_n low mid-revolution with host_req pending -> w=b=0, M_out=0, no ack; RAM[2] data preserved on host readback.

Source files
------------

// File: rtl/drum_line.sv
// drum_line: one recirculating drum track held in a word RAM, with a
// serial read head, a serial write amplifier and a host word port.
// Ports:
//   CLOCK, rst_n                 clock, async active-low reset
//   BIT_EN                       one-cycle strobe per drum bit time
//   M_in / M_out                 serial write bit / serial read bit
//   WORD_IDX / BIT_IDX           current head position (w, b)
//   host_req/we/addr/wdata       host word request (held until ack)
//   host_ack / host_rdata        completion pulse / read data
module drum_line #(
    parameter int WORDS     = 108,
    parameter int WORD_BITS = 29
) (
    input  logic                 CLOCK,
    input  logic                 rst_n,
    input  logic                 BIT_EN,
    input  logic                 M_in,
    output logic                 M_out,
    output logic [6:0]           WORD_IDX,
    output logic [4:0]           BIT_IDX,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [6:0]           host_addr,
    input  logic [WORD_BITS-1:0] host_wdata,
    output logic                 host_ack,
    output logic [WORD_BITS-1:0] host_rdata
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [6:0] W_LAST = 7'(WORDS - 1);
    localparam logic [6:0] W_LIM  = 7'(WORDS);
    localparam logic [4:0] B_LAST = 5'(WORD_BITS - 1);
    localparam logic [4:0] B_PF   = 5'(WORD_BITS - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_ACK
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WORD_BITS-1:0] mem [WORDS];

    logic [6:0]           w;
    logic [4:0]           b;
    logic [6:0]           w_next;
    logic [WORD_BITS-1:0] out_sr;
    logic [WORD_BITS-1:0] asm_q;
    logic [WORD_BITS-1:0] pf_q;
    logic                 pf_done;

    logic drum_wb;
    logic drum_pf;
    logic drum_busy;
    logic addr_oor;
    logic blocked;
    logic free;
    logic grant;

    assign WORD_IDX = w;
    assign BIT_IDX  = b;
    assign M_out    = out_sr[b];
    assign host_ack = (state_q == S_ACK);

    assign w_next = (w == W_LAST) ? 7'd0 : w + 7'd1;

    // Drum traffic owns the RAM port: writeback on the last BIT_EN of a
    // word, and one prefetch of the next word in the idle cycle that
    // follows the step onto bit WORD_BITS-2.
    assign drum_wb   = BIT_EN && (b == B_LAST);
    assign drum_pf   = !BIT_EN && (b == B_PF) && !pf_done;
    assign drum_busy = drum_wb || drum_pf;

    // The word under the head, and the next word once its prefetch
    // window opens, are in flight in the shift/assembly registers; a
    // host access there would be lost or overwritten.
    assign addr_oor = (host_addr >= W_LIM);
    assign blocked  = (host_addr == w)
                   || ((b >= B_PF) && (host_addr == w_next));

    // Out-of-range requests never touch the RAM, so nothing holds them.
    assign free = addr_oor || (!blocked && !drum_busy);

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (host_req) begin
                    state_d = free ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!host_req) begin
                    state_d = S_IDLE;
                end else if (free) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!host_req) begin
                    state_d = S_IDLE;
                end else if (free) begin
                    grant   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Head position, serial assembly and output shift registers.
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            w       <= '0;
            b       <= '0;
            out_sr  <= '0;
            asm_q   <= '0;
            pf_q    <= '0;
            pf_done <= 1'b0;
        end else begin
            if (BIT_EN) begin
                asm_q[b] <= M_in;
                pf_done  <= 1'b0;
                if (b == B_LAST) begin
                    b      <= '0;
                    w      <= w_next;
                    out_sr <= pf_q;
                end else begin
                    b <= b + 5'd1;
                end
            end
            if (drum_pf) begin
                pf_q    <= mem[w_next[AW-1:0]];
                pf_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata <= '0;
        end else if (grant && !host_we) begin
            host_rdata <= addr_oor ? '0 : mem[host_addr[AW-1:0]];
        end
    end

    // Word RAM: contents survive reset. The final bit goes straight in
    // from M_in since it is not yet in the assembly register.
    always_ff @(posedge CLOCK) begin
        if (drum_wb) begin
            mem[w[AW-1:0]] <= {M_in, asm_q[WORD_BITS-2:0]};
        end else if (grant && host_we && !addr_oor) begin
            mem[host_addr[AW-1:0]] <= host_wdata;
        end
    end

endmodule

// File: tb/tb_drum_line.sv
// tb_drum_line: directed bench for drum_line with a 4-word line
// and a 108-word line sharing clock, reset, BIT_EN and M_in.
module tb_drum_line;

    localparam int REV4 = 116;
    localparam logic [28:0] PAT  = 29'h15555555;
    localparam logic [28:0] NEWW = 29'h0ABCDEF;
    localparam logic [28:0] D108 = 29'h1234567;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_en = 1'b0;
    logic        m_in = 1'b0;
    logic        host_we = 1'b0;
    logic [6:0]  host_addr = '0;
    logic [28:0] host_wdata = '0;

    logic        req4 = 1'b0;
    logic        m_out4;
    logic [6:0]  w4;
    logic [4:0]  b4;
    logic        ack4;
    logic [28:0] rdata4;

    logic        req108 = 1'b0;
    logic        m_out108;
    logic [6:0]  w108;
    logic [4:0]  b108;
    logic        ack108;
    logic [28:0] rdata108;

    int total = 0;
    int bad = 0;
    int ticks = 0;
    int acks4 = 0;
    int acks108 = 0;

    logic [6:0]  ack_w;
    logic [28:0] ack_data;
    logic [28:0] ack_data108;
    logic        loop = 1'b0;
    logic        min_bit = 1'b0;

    drum_line #(.WORDS(4), .WORD_BITS(29)) u4 (
        .CLOCK(clk), .rst_n(rst_n), .BIT_EN(bit_en), .M_in(m_in),
        .M_out(m_out4), .WORD_IDX(w4), .BIT_IDX(b4),
        .host_req(req4), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(ack4), .host_rdata(rdata4)
    );

    drum_line #(.WORDS(108), .WORD_BITS(29)) u108 (
        .CLOCK(clk), .rst_n(rst_n), .BIT_EN(bit_en), .M_in(m_in),
        .M_out(m_out108), .WORD_IDX(w108), .BIT_IDX(b108),
        .host_req(req108), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(ack108), .host_rdata(rdata108)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic en);
        @(negedge clk);
        if (ack4) begin
            acks4++;
            ack_w = w4;
            ack_data = rdata4;
            req4 = 1'b0;
        end
        if (ack108) begin
            acks108++;
            ack_data108 = rdata108;
            req108 = 1'b0;
        end
        bit_en = en;
        m_in = en ? (loop ? m_out4 : min_bit) : 1'b0;
    endtask

    task automatic tick();
        step(1'b1);
        step(1'b0);
        ticks++;
    endtask

    task automatic goto4(input int target);
        for (int k = 0; k < REV4; k++) begin
            if ((ticks % REV4) == target) break;
            tick();
        end
    endtask

    task automatic host4(input logic we, input logic [6:0] addr,
                         input logic [28:0] data, input logic use_tick,
                         input int budget, output logic got);
        int n0;
        n0 = acks4;
        host_we = we;
        host_addr = addr;
        host_wdata = data;
        req4 = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (acks4 != n0) break;
            if (use_tick) tick();
            else step(1'b0);
        end
        got = (acks4 != n0);
        req4 = 1'b0;
    endtask

    task automatic host108(input logic we, input logic [6:0] addr,
                           input logic [28:0] data, output logic got);
        int n0;
        n0 = acks108;
        host_we = we;
        host_addr = addr;
        host_wdata = data;
        req108 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (acks108 != n0) break;
            step(1'b0);
        end
        got = (acks108 != n0);
        req108 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b0);
        step(1'b0);
        total++;
        if (w4 !== 7'd0) begin
            bad++; $display("FAIL rst_w4 got=%0d exp=0", w4);
        end
        total++;
        if (b4 !== 5'd0) begin
            bad++; $display("FAIL rst_b4 got=%0d exp=0", b4);
        end
        total++;
        if (m_out4 !== 1'b0) begin
            bad++; $display("FAIL rst_mout got=%0b exp=0", m_out4);
        end
        total++;
        if (ack4 !== 1'b0) begin
            bad++; $display("FAIL rst_ack got=%0b exp=0", ack4);
        end
        total++;
        if (rdata4 !== 29'd0) begin
            bad++; $display("FAIL rst_rdata got=%0h exp=0", rdata4);
        end
        total++;
        if (w108 !== 7'd0 || b108 !== 5'd0) begin
            bad++; $display("FAIL rst_pos108 got=%0d/%0d exp=0/0", w108, b108);
        end
        rst_n = 1'b1;
        ticks = 0;
    endtask

    task automatic test_zero_fill();
        loop = 1'b0;
        min_bit = 1'b0;
        for (int i = 0; i < REV4; i++) tick();
        total++;
        if (w4 !== 7'd0 || b4 !== 5'd0) begin
            bad++; $display("FAIL rev_pos got=%0d/%0d exp=0/0", w4, b4);
        end
    endtask

    task automatic test_pulse();
        int errs;
        errs = 0;
        for (int i = 0; i < 2 * REV4; i++) begin
            logic e;
            e = (i == REV4 + 34);
            total++;
            if (m_out4 !== e) begin
                bad++;
                $display("FAIL pulse_i%0d got=%0b exp=%0b", i, m_out4, e);
            end
            min_bit = (i == 34);
            tick();
        end
        min_bit = 1'b0;
    endtask

    task automatic test_loop_pattern();
        logic got;
        logic [28:0] pat;
        pat = PAT;
        host4(1'b1, 7'd2, PAT, 1'b0, 20, got);
        total++;
        if (got !== 1'b1) begin
            bad++; $display("FAIL wr2_ack got=%0b exp=1", got);
        end
        loop = 1'b1;
        for (int i = 0; i < 2 * REV4; i++) begin
            int p;
            logic e;
            p = i % REV4;
            e = (p / 29 == 2) ? pat[p % 29] : 1'b0;
            total++;
            if (m_out4 !== e) begin
                bad++;
                $display("FAIL loop_i%0d got=%0b exp=%0b", i, m_out4, e);
            end
            tick();
        end
    endtask

    task automatic test_read_current();
        logic got;
        goto4(2 * 29 + 3);
        host4(1'b0, 7'd2, 29'd0, 1'b1, 60, got);
        total++;
        if (got !== 1'b1) begin
            bad++; $display("FAIL rdcur_ack got=%0b exp=1", got);
        end
        total++;
        if (ack_w !== 7'd3) begin
            bad++; $display("FAIL rdcur_w got=%0d exp=3", ack_w);
        end
        total++;
        if (ack_data !== PAT) begin
            bad++; $display("FAIL rdcur_data got=%0h exp=%0h", ack_data, PAT);
        end
    endtask

    task automatic test_write_next();
        logic got;
        logic [28:0] d;
        d = NEWW;
        goto4(2 * 29 + 27);
        host4(1'b1, 7'd3, NEWW, 1'b1, 150, got);
        total++;
        if (got !== 1'b1) begin
            bad++; $display("FAIL wrnext_ack got=%0b exp=1", got);
        end
        total++;
        if (ack_w !== 7'd0) begin
            bad++; $display("FAIL wrnext_w got=%0d exp=0", ack_w);
        end
        goto4(3 * 29);
        for (int bb = 0; bb < 29; bb++) begin
            total++;
            if (m_out4 !== d[bb]) begin
                bad++;
                $display("FAIL wrnext_b%0d got=%0b exp=%0b", bb, m_out4, d[bb]);
            end
            tick();
        end
    endtask

    task automatic test_reset_pending();
        logic got;
        int n0;
        goto4(2 * 29 + 2);
        total++;
        if (m_out4 !== 1'b1) begin
            bad++; $display("FAIL pre_rst_mout got=%0b exp=1", m_out4);
        end
        host_we = 1'b0;
        host_addr = 7'd2;
        req4 = 1'b1;
        n0 = acks4;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        if (w4 !== 7'd0 || b4 !== 5'd0) begin
            bad++; $display("FAIL midrst_pos got=%0d/%0d exp=0/0", w4, b4);
        end
        total++;
        if (m_out4 !== 1'b0) begin
            bad++; $display("FAIL midrst_mout got=%0b exp=0", m_out4);
        end
        step(1'b0);
        step(1'b0);
        req4 = 1'b0;
        rst_n = 1'b1;
        ticks = 0;
        for (int k = 0; k < 6; k++) step(1'b0);
        total++;
        if (acks4 !== n0) begin
            bad++; $display("FAIL midrst_noack got=%0d exp=%0d", acks4, n0);
        end
        host4(1'b0, 7'd2, 29'd0, 1'b0, 20, got);
        total++;
        if (got !== 1'b1 || ack_data !== PAT) begin
            bad++;
            $display("FAIL midrst_ram2 got=%0h exp=%0h", ack_data, PAT);
        end
    endtask

    task automatic test_wrap_oor();
        logic got;
        for (int i = 0; i < 29; i++) tick();
        total++;
        if (w108 !== 7'd1 || b108 !== 5'd0) begin
            bad++; $display("FAIL pos29 got=%0d/%0d exp=1/0", w108, b108);
        end
        for (int i = 29; i < 3131; i++) tick();
        total++;
        if (w108 !== 7'd107 || b108 !== 5'd28) begin
            bad++; $display("FAIL pos3131 got=%0d/%0d exp=107/28", w108, b108);
        end
        tick();
        total++;
        if (w108 !== 7'd0 || b108 !== 5'd0) begin
            bad++; $display("FAIL pos3132 got=%0d/%0d exp=0/0", w108, b108);
        end
        total++;
        if (w4 !== 7'd0 || b4 !== 5'd0) begin
            bad++; $display("FAIL pos4_3132 got=%0d/%0d exp=0/0", w4, b4);
        end
        host108(1'b1, 7'd5, D108, got);
        host108(1'b0, 7'd5, 29'd0, got);
        total++;
        if (got !== 1'b1 || ack_data108 !== D108) begin
            bad++; $display("FAIL rd108_5 got=%0h exp=%0h", ack_data108, D108);
        end
        host108(1'b0, 7'd120, 29'd0, got);
        total++;
        if (got !== 1'b1) begin
            bad++; $display("FAIL oor108_ack got=%0b exp=1", got);
        end
        total++;
        if (ack_data108 !== 29'd0) begin
            bad++; $display("FAIL oor108_data got=%0h exp=0", ack_data108);
        end
        host4(1'b0, 7'd120, 29'd0, 1'b0, 20, got);
        total++;
        if (got !== 1'b1 || ack_data !== 29'd0) begin
            bad++; $display("FAIL oor4_rd got=%0h exp=0", ack_data);
        end
    endtask

    initial begin
        test_reset();
        test_zero_fill();
        test_pulse();
        test_loop_pattern();
        test_read_current();
        test_write_next();
        test_reset_pending();
        test_wrap_oor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
